// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC phase generator and rotator.
// Holds the angle width, rotator latency, FSM encoding and LFSR dither constants.
package cordic_pkg;

  localparam int unsigned ANGLE_WIDTH    = 32;
  localparam int unsigned CORDIC_LATENCY = 17;
  localparam logic [31:0] QUARTER_TURN   = 32'h4000_0000;

  // Galois LFSR for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [0:0] {
    FIXED = 1'b0,
    SWEEP = 1'b1
  } phase_fsm_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/cordic_valid_delay.sv
// Fixed-latency 1-bit shift register with synchronous reset.
// Keeps a valid flag aligned with the rotator pipeline; no merging or dropping of valids.
module cordic_valid_delay #(
  parameter int unsigned DEPTH = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] shift_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) begin
          shift_q <= '0;
        end else begin
          shift_q <= in_valid;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (rst) begin
          shift_q <= '0;
        end else begin
          shift_q <= {shift_q[DEPTH-2:0], in_valid};
        end
      end
    end
  endgenerate

  assign out_valid = shift_q[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase-accumulator NCO with phase offset and linear frequency sweep, feeding the CORDIC rotator.
// Optional LSB dither of the output angle is enabled by defining PHASE_DITHER_EN.
module cordic_phase_gen #(
  parameter int unsigned ANGLE_WIDTH = cordic_pkg::ANGLE_WIDTH,
  parameter int unsigned PIPE_DEPTH  = cordic_pkg::CORDIC_LATENCY,
  parameter int unsigned DITHER_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   fcw_load,
  input  logic [ANGLE_WIDTH-1:0] fcw_in,
  input  logic [ANGLE_WIDTH-1:0] phase_off,
  input  logic                   sweep_start,
  input  logic [ANGLE_WIDTH-1:0] sweep_step,
  input  logic [ANGLE_WIDTH-1:0] sweep_stop,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic                   angle_valid,
  output logic                   out_valid,
  output logic                   sweeping,
  output logic                   sweep_done
);

  import cordic_pkg::*;

  localparam int unsigned AW = ANGLE_WIDTH;
  localparam logic [AW-1:0] DITHER_MASK = AW'((64'd1 << DITHER_BITS) - 64'd1);

  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] fcw_q, fcw_d;
  logic [AW-1:0] step_q, step_d;
  logic [AW-1:0] stop_q, stop_d;
  logic [AW-1:0] angle_q, angle_d;
  logic          angle_valid_q;
  logic          sweep_done_q, sweep_done_d;
  logic          sweeping_q;
  phase_fsm_t    state_q, state_d;
  logic [AW:0]   sweep_sum;
  logic [AW-1:0] dither;

`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (enable) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign dither = AW'(lfsr_q) & DITHER_MASK;
`else
  logic unused_dither_cfg;

  assign dither            = '0;
  assign unused_dither_cfg = ^{DITHER_MASK, LFSR_SEED, LFSR_TAPS};
`endif

  always_comb begin
    acc_d        = acc_q;
    angle_d      = angle_q;
    fcw_d        = fcw_q;
    step_d       = step_q;
    stop_d       = stop_q;
    state_d      = state_q;
    sweep_done_d = 1'b0;
    // One extra bit so fcw + step can never wrap past stop
    sweep_sum    = {1'b0, fcw_q} + {1'b0, step_q};

    if (enable) begin
      angle_d = acc_q + phase_off + dither;
      acc_d   = acc_q + fcw_q;
    end

    if (fcw_load) begin
      fcw_d   = fcw_in;
      state_d = FIXED;
    end else if (sweep_start && (state_q == FIXED)) begin
      step_d = sweep_step;
      stop_d = sweep_stop;
      if ((sweep_step == '0) || (fcw_q >= sweep_stop)) begin
        sweep_done_d = 1'b1;
      end else begin
        state_d = SWEEP;
      end
    end else if ((state_q == SWEEP) && enable) begin
      if (sweep_sum >= {1'b0, stop_q}) begin
        fcw_d        = stop_q;
        state_d      = FIXED;
        sweep_done_d = 1'b1;
      end else begin
        fcw_d = sweep_sum[AW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      fcw_q         <= '0;
      step_q        <= '0;
      stop_q        <= '0;
      angle_q       <= '0;
      angle_valid_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      sweeping_q    <= 1'b0;
      state_q       <= FIXED;
    end else begin
      acc_q         <= acc_d;
      fcw_q         <= fcw_d;
      step_q        <= step_d;
      stop_q        <= stop_d;
      angle_q       <= angle_d;
      angle_valid_q <= enable;
      sweep_done_q  <= sweep_done_d;
      sweeping_q    <= (state_d == SWEEP);
      state_q       <= state_d;
    end
  end

  cordic_valid_delay #(
    .DEPTH (PIPE_DEPTH)
  ) u_valid_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (angle_valid_q),
    .out_valid (out_valid)
  );

  assign angle       = angle_q;
  assign angle_valid = angle_valid_q;
  assign sweeping    = sweeping_q;
  assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen: per-cycle vector table plus hand-written
// sequences for wrap-around, valid latency and reset during an active sweep.
module tb_cordic_phase_gen;

  import cordic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fcw_load;
  logic [31:0] fcw_in;
  logic [31:0] phase_off;
  logic        sweep_start;
  logic [31:0] sweep_step;
  logic [31:0] sweep_stop;
  logic [31:0] angle;
  logic        angle_valid;
  logic        out_valid;
  logic        sweeping;
  logic        sweep_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_phase_gen dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fcw_load    (fcw_load),
    .fcw_in      (fcw_in),
    .phase_off   (phase_off),
    .sweep_start (sweep_start),
    .sweep_step  (sweep_step),
    .sweep_stop  (sweep_stop),
    .angle       (angle),
    .angle_valid (angle_valid),
    .out_valid   (out_valid),
    .sweeping    (sweeping),
    .sweep_done  (sweep_done)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        load;
    logic [31:0] fcw;
    logic [31:0] poff;
    logic        start;
    logic [31:0] step;
    logic [31:0] stop;
    logic [31:0] e_angle;
    logic        e_av;
    logic        e_swp;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic l, logic [31:0] f, logic [31:0] p,
                              logic s, logic [31:0] st, logic [31:0] sp,
                              logic [31:0] ea, logic eav, logic esw, logic edn);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.fcw = f; v.poff = p;
    v.start = s; v.step = st; v.stop = sp;
    v.e_angle = ea; v.e_av = eav; v.e_swp = esw; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic [31:0] f,
                       input logic [31:0] p, input logic s, input logic [31:0] st,
                       input logic [31:0] sp);
    rst = r; enable = e; fcw_load = l; fcw_in = f; phase_off = p;
    sweep_start = s; sweep_step = st; sweep_stop = sp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_sweep(input logic [31:0] stop, input logic [31:0] a4, input logic [31:0] a5);
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h100, stop, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h000, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h100, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h300, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h600, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, a4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, a5, 1, 0, 0));
  endtask

  initial begin
    logic [31:0] exp_a;

    drive(1, 1, 0, 0, 0, 0, 0, 0);

    // Reset held with enable high
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fcw=0 with 90 degree offset
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 0, 0, QUARTER_TURN, 0, 0, 0, QUARTER_TURN, 1, 0, 0));
    // Sweep to exact stop, then sweep clamped at stop
    add_sweep(32'h400, 32'h0A00, 32'h0E00);
    add_sweep(32'h350, 32'h0950, 32'h0CA0);
    // fcw already >= stop, then zero step: immediate done, no sweep
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h100, 32'h400, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h1000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fcw_load and sweep_start together: load wins
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h10, 0, 1, 32'h10, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h00, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h20, 1, 0, 0));
    // sweep_start ignored in SWEEP; fcw_load aborts the sweep without sweep_done
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h100, 32'h1000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 32'h800, 32'h200, 32'h000, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h40, 0, 0, 0, 0, 32'h100, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h300, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h340, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h380, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].fcw, vecs[i].poff,
            vecs[i].start, vecs[i].step, vecs[i].stop);
      tick();
      chk($sformatf("vec%0d angle", i), angle, vecs[i].e_angle);
      chk($sformatf("vec%0d angle_valid", i), 32'(angle_valid), 32'(vecs[i].e_av));
      chk($sformatf("vec%0d sweeping", i), 32'(sweeping), 32'(vecs[i].e_swp));
      chk($sformatf("vec%0d sweep_done", i), 32'(sweep_done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(0));
    end

    // Continuous run with fcw = 1/256 turn: 257th sample wraps to 0
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 32'h0100_0000, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 260; k++) begin
      tick();
      exp_a = 32'(k - 1) << 24;
      chk($sformatf("ramp%0d angle", k), angle, exp_a);
      chk($sformatf("ramp%0d out_valid", k), 32'(out_valid), 32'(k >= 18));
    end

    // Single enable pulse: out_valid exactly 17 cycles after angle_valid, one cycle wide
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("pulse angle_valid", 32'(angle_valid), 32'(1));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 2; k <= 30; k++) begin
      tick();
      chk($sformatf("pulse%0d angle_valid", k), 32'(angle_valid), 32'(0));
      chk($sformatf("pulse%0d out_valid", k), 32'(out_valid), 32'(k == 18));
    end

    // Reset during a sweep with five valids in flight
    drive(0, 0, 1, 32'h100, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h100, 32'h10000);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick();
    chk("midsweep sweeping", 32'(sweeping), 32'(1));
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rst sweeping", 32'(sweeping), 32'(0));
    chk("rst angle", angle, 32'h0);
    chk("rst angle_valid", 32'(angle_valid), 32'(0));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 25; k++) begin
      tick();
      chk($sformatf("flush%0d out_valid", k), 32'(out_valid), 32'(0));
      chk($sformatf("flush%0d sweeping", k), 32'(sweeping), 32'(0));
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst%0d angle", k), angle, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
